alu_unit: RTL and testbench

- Arithmetic stage directly downstream of the accumulator.
- Consumes the accumulator's constant ALU output (ACC) and holds the B register, loaded from DBUS.
- Produces the single-cycle add/subtract result and a multi-cycle 8x8 shift-add multiply.
- Keeps registered carry/zero flags for the controller-sequencer and drives results back onto DBUS through tri-state enables.

---
 rtl/sap_pkg.sv | 16 +
 rtl/alu_unit_if.sv | 30 +++
 rtl/alu_mul_seq.sv | 92 +++++++++
 rtl/alu_unit.sv | 88 ++++++++
 tb/tb_alu_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared constants and types for the SAP arithmetic stage.
// Provides the default data width, the multiply FSM state type and the Su opcode values.
package sap_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/alu_unit_if.sv
// Control/status bundle between the controller-sequencer and the ALU stage.
// DBUS stays a separate inout because it is a shared tri-state net.
interface alu_unit_if
  import sap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             nLb;
  logic             Su;
  logic             Eu;
  logic             Mu;
  logic             Ep;
  logic [WIDTH-1:0] ACC;
  logic             BUSY;
  logic             MDONE;
  logic             CF;
  logic             ZF;

  modport master (
    output nLb, Su, Eu, Mu, Ep, ACC,
    input  BUSY, MDONE, CF, ZF
  );

  modport slave (
    input  nLb, Su, Eu, Mu, Ep, ACC,
    output BUSY, MDONE, CF, ZF
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier: one partial product per clock, WIDTH iterations,
// then a single commit cycle that publishes the product and its flag values.
module alu_mul_seq
  import sap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplr_in,
  output logic             busy,
  output logic             mdone,
  output logic [WIDTH-1:0] prod_lo,
  output logic             done_cf,
  output logic             done_zf,
  output logic             flag_we
);

  localparam int MUL_CYCLES = WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

  mul_state_t         state_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] wacc_reg;
  logic [WIDTH-1:0]   mplr_reg;
  logic [CW-1:0]      count_reg;
  logic               busy_reg;
  logic               mdone_reg;
  // Only the low byte of the product ever leaves this stage, so only it is kept.
  logic [WIDTH-1:0]   prod_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      wacc_reg  <= '0;
      mplr_reg  <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      mdone_reg <= 1'b0;
      prod_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg <= {{WIDTH{1'b0}}, mcand_in};
            mplr_reg  <= mplr_in;
            wacc_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (mplr_reg[0]) begin
            wacc_reg <= wacc_reg + mcand_reg;
          end
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_reg >> 1;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_COUNT) begin
            mdone_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          prod_reg  <= wacc_reg[WIDTH-1:0];
          mdone_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          mdone_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // WACC is stable throughout DONE, so the flag values can be formed combinationally.
  assign done_zf = (wacc_reg == '0);
  assign done_cf = |wacc_reg[2*WIDTH-1:WIDTH];
  assign flag_we = mdone_reg;
  assign busy    = busy_reg;
  assign mdone   = mdone_reg;
  assign prod_lo = prod_reg;

endmodule

// File: rtl/alu_unit.sv
// ALU stage top: B register, combinational add/subtract, registered carry/zero flags,
// the shift-add multiplier and the tri-state drive back onto DBUS.
module alu_unit
  import sap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             nRST,
  alu_unit_if.slave        bus,
  inout  wire  [WIDTH-1:0] DBUS
);

  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             cf_reg;
  logic             zf_reg;

  logic             mul_busy;
  logic             mul_mdone;
  logic [WIDTH-1:0] prod_lo;
  logic             done_cf;
  logic             done_zf;
  logic             flag_we;

  logic             drive_en;
  logic [WIDTH-1:0] drive_val;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (bus.Mu),
    .mcand_in (bus.ACC),
    .mplr_in  (b_reg),
    .busy     (mul_busy),
    .mdone    (mul_mdone),
    .prod_lo  (prod_lo),
    .done_cf  (done_cf),
    .done_zf  (done_zf),
    .flag_we  (flag_we)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      b_reg <= '0;
    end else if (!bus.nLb) begin
      b_reg <= DBUS;
    end
  end

  // Subtract is ACC + ~B + 1, so carry out means "no borrow" (ACC >= B).
  assign sum    = {1'b0, bus.ACC}
                + {1'b0, (bus.Su == SUB) ? ~b_reg : b_reg}
                + {{WIDTH{1'b0}}, bus.Su};
  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

  // The multiplier commit owns the flags on its edge; an Eu on that edge only drives the bus.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cf_reg <= 1'b0;
      zf_reg <= 1'b0;
    end else if (flag_we) begin
      cf_reg <= done_cf;
      zf_reg <= done_zf;
    end else if (bus.Eu) begin
      cf_reg <= carry;
      zf_reg <= (result == '0);
    end
  end

  always_comb begin
    drive_en  = bus.Eu | bus.Ep;
    drive_val = bus.Eu ? result : prod_lo;
  end

  assign DBUS      = drive_en ? drive_val : {WIDTH{1'bz}};

  assign bus.BUSY  = mul_busy;
  assign bus.MDONE = mul_mdone;
  assign bus.CF    = cf_reg;
  assign bus.ZF    = zf_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus randomized add/sub and multiply
// operations checked against an arithmetic reference model.
module tb_alu_unit;
  import sap_pkg::*;

  localparam int W    = DEF_WIDTH;
  localparam int MASK = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         nRST;
  wire  [W-1:0] DBUS;
  logic         tb_drv_en;
  logic [W-1:0] tb_drv;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the stage should hold, in plain arithmetic terms.
  int   m_b;
  int   m_prod;
  logic m_cf;
  logic m_zf;

  alu_unit_if #(.WIDTH(W)) bus ();

  alu_unit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus),
    .DBUS (DBUS)
  );

  always #5 CLK = ~CLK;

  assign DBUS = tb_drv_en ? tb_drv : {W{1'bz}};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.nLb   = 1'b1;
    bus.Su    = ADD;
    bus.Eu    = 1'b0;
    bus.Mu    = 1'b0;
    bus.Ep    = 1'b0;
    tb_drv_en = 1'b0;
    tb_drv    = '0;
  endtask

  task automatic ref_addsub(input int a, input int b, input logic su,
                            output logic [W-1:0] res, output logic c, output logic z);
    int t;
    if (su == SUB) begin
      t = a - b;
      c = (a >= b);
    end else begin
      t = a + b;
      c = (t > MASK);
    end
    res = W'(t & MASK);
    z   = (res == '0);
  endtask

  task automatic load_b(input int v);
    tb_drv    = W'(v);
    tb_drv_en = 1'b1;
    bus.nLb   = 1'b0;
    tick();
    bus.nLb   = 1'b1;
    tb_drv_en = 1'b0;
    m_b       = v;
  endtask

  task automatic do_addsub(input int a, input int b, input logic su, input logic with_ep);
    logic [W-1:0] res;
    logic c, z;
    load_b(b);
    ref_addsub(a, b, su, res, c, z);
    bus.ACC = W'(a);
    bus.Su  = su;
    bus.Eu  = 1'b1;
    bus.Ep  = with_ep;
    #1;
    checks++;
    if (DBUS !== res) begin
      errors++;
      $display("FAIL addsub_bus: a=%0h b=%0h su=%0b got %0h expected %0h", a, b, su, DBUS, res);
    end
    tick();
    bus.Eu = 1'b0;
    bus.Ep = 1'b0;
    m_cf = c;
    m_zf = z;
    checks++;
    if ({bus.CF, bus.ZF} !== {c, z}) begin
      errors++;
      $display("FAIL addsub_flags: a=%0h b=%0h su=%0b got cf=%0b zf=%0b expected cf=%0b zf=%0b",
               a, b, su, bus.CF, bus.ZF, c, z);
    end
    $display("addsub a=%02h b=%02h su=%0b ep=%0b -> res=%02h cf=%0b zf=%0b", a, b, su, with_ep, res, c, z);
  endtask

  // Runs one multiply and checks the 9-cycle BUSY window, the single MDONE pulse and the commit.
  task automatic do_mul(input int a, input int b);
    int p;
    logic [W-1:0] lo;
    p  = a * b;
    lo = W'(p & MASK);
    load_b(b);
    bus.ACC = W'(a);
    bus.Mu  = 1'b1;
    tick();
    bus.Mu  = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      checks++;
      if (bus.BUSY !== 1'b1 || bus.MDONE !== (k == W + 1)) begin
        errors++;
        $display("FAIL mul_timing: cycle %0d got busy=%0b mdone=%0b expected busy=1 mdone=%0b",
                 k, bus.BUSY, bus.MDONE, (k == W + 1));
      end
      tick();
    end
    m_prod = p;
    m_cf   = (p > MASK);
    m_zf   = (p == 0);
    checks++;
    if ({bus.BUSY, bus.MDONE, bus.CF, bus.ZF} !== {1'b0, 1'b0, m_cf, m_zf}) begin
      errors++;
      $display("FAIL mul_commit: a=%0h b=%0h got busy=%0b mdone=%0b cf=%0b zf=%0b expected 0 0 %0b %0b",
               a, b, bus.BUSY, bus.MDONE, bus.CF, bus.ZF, m_cf, m_zf);
    end
    bus.Ep = 1'b1;
    #1;
    checks++;
    if (DBUS !== lo) begin
      errors++;
      $display("FAIL mul_ep: a=%0h b=%0h got %0h expected %0h", a, b, DBUS, lo);
    end
    bus.Ep = 1'b0;
    $display("mul a=%02h b=%02h -> prod=%04h cf=%0b zf=%0b", a, b, p, m_cf, m_zf);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.ACC = '0;
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    m_b = 0; m_prod = 0; m_cf = 1'b0; m_zf = 1'b0;
    checks++;
    if ({bus.BUSY, bus.MDONE, bus.CF, bus.ZF} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got busy=%0b mdone=%0b cf=%0b zf=%0b expected all 0",
               bus.BUSY, bus.MDONE, bus.CF, bus.ZF);
    end
    tb_drv = 8'h5A;
    tb_drv_en = 1'b1;
    #1;
    checks++;
    if (DBUS !== 8'h5A) begin
      errors++;
      $display("FAIL reset_bus_released: got %0h expected 5a", DBUS);
    end
    tb_drv_en = 1'b0;
    bus.Ep = 1'b1;
    #1;
    checks++;
    if (DBUS !== 8'h00) begin
      errors++;
      $display("FAIL reset_prod: got %0h expected 0", DBUS);
    end
    bus.Ep  = 1'b0;
    bus.ACC = 8'h33;
    bus.Eu  = 1'b1;
    #1;
    checks++;
    if (DBUS !== 8'h33) begin
      errors++;
      $display("FAIL reset_b_zero: got %0h expected 33", DBUS);
    end
    bus.Eu = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_add();
    do_addsub(8'h14, 8'h0A, ADD, 1'b0);
    do_addsub(8'hF6, 8'h0A, ADD, 1'b0);
    do_addsub(8'h80, 8'h7F, ADD, 1'b1);
  endtask

  task automatic test_sub();
    do_addsub(8'h05, 8'h07, SUB, 1'b0);
    do_addsub(8'h07, 8'h07, SUB, 1'b1);
    do_addsub(8'h00, 8'hFF, SUB, 1'b0);
  endtask

  task automatic test_random_addsub();
    for (int i = 0; i < 16; i++) begin
      do_addsub(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                logic'($urandom_range(0, 1)), 1'b0);
      bus.ACC = W'($urandom_range(0, MASK));
      bus.Ep  = 1'b1;
      tick();
      bus.Ep  = 1'b0;
      checks++;
      if ({bus.CF, bus.ZF} !== {m_cf, m_zf}) begin
        errors++;
        $display("FAIL flags_hold: got cf=%0b zf=%0b expected cf=%0b zf=%0b", bus.CF, bus.ZF, m_cf, m_zf);
      end
    end
  endtask

  task automatic test_multiply();
    do_mul(8'h0C, 8'h0D);
    do_mul(8'h20, 8'h10);
    do_mul(8'h00, 8'h55);
    do_mul(8'hFF, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      do_mul(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    end
  endtask

  // B reload, Mu re-pulse, ACC change and Ep during RUN; Eu on the commit edge.
  task automatic test_interference(input int a, input int b);
    int p0, p, acc_now;
    logic [W-1:0] res;
    logic c, z;
    p0 = m_prod;
    p  = a * b;
    acc_now = a;
    load_b(b);
    bus.ACC = W'(a);
    bus.Mu  = 1'b1;
    tick();
    bus.Mu  = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      if (k == 4) begin
        tb_drv = 8'hFF;
        tb_drv_en = 1'b1;
        bus.nLb = 1'b0;
      end
      if (k == 5) begin
        bus.Mu = 1'b1;
        bus.Ep = 1'b1;
        acc_now = (~a) & MASK;
        bus.ACC = W'(acc_now);
      end
      if (k == 6) bus.Mu = 1'b0;
      if (k == W + 1) begin
        bus.Eu = 1'b1;
        bus.Su = ADD;
      end
      #1;
      if (bus.Eu) begin
        ref_addsub(acc_now, 8'hFF, ADD, res, c, z);
        checks++;
        if (DBUS !== res) begin
          errors++;
          $display("FAIL intf_eu_bus: got %0h expected %0h", DBUS, res);
        end
      end else if (bus.Ep) begin
        checks++;
        if (DBUS !== W'(p0 & MASK)) begin
          errors++;
          $display("FAIL intf_ep_prev: cycle %0d got %0h expected %0h", k, DBUS, W'(p0 & MASK));
        end
      end
      checks++;
      if (bus.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL intf_busy: cycle %0d got %0b expected 1", k, bus.BUSY);
      end
      tick();
      if (k == 4) begin
        bus.nLb = 1'b1;
        tb_drv_en = 1'b0;
      end
    end
    bus.Eu = 1'b0;
    m_b = 8'hFF;
    m_prod = p;
    m_cf = (p > MASK);
    m_zf = (p == 0);
    #1;
    checks++;
    if ({bus.BUSY, bus.CF, bus.ZF} !== {1'b0, m_cf, m_zf} || DBUS !== W'(p & MASK)) begin
      errors++;
      $display("FAIL intf_commit: got busy=%0b cf=%0b zf=%0b bus=%0h expected 0 %0b %0b %0h",
               bus.BUSY, bus.CF, bus.ZF, DBUS, m_cf, m_zf, W'(p & MASK));
    end
    tick();
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL intf_no_restart: got busy=%0b expected 0", bus.BUSY);
    end
    bus.Ep = 1'b0;
    bus.ACC = 8'h00;
    bus.Eu = 1'b1;
    #1;
    checks++;
    if (DBUS !== W'(m_b)) begin
      errors++;
      $display("FAIL intf_b_reloaded: got %0h expected %0h", DBUS, W'(m_b));
    end
    bus.Eu = 1'b0;
    $display("interference a=%02h b=%02h -> prod=%04h prev=%04h", a, b, p, p0);
  endtask

  task automatic test_reset_mid();
    logic saw_activity;
    load_b(8'h37);
    bus.ACC = 8'h5B;
    bus.Mu = 1'b1;
    tick();
    bus.Mu = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    m_b = 0; m_prod = 0; m_cf = 1'b0; m_zf = 1'b0;
    checks++;
    if ({bus.BUSY, bus.MDONE, bus.CF, bus.ZF} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_status: got busy=%0b mdone=%0b cf=%0b zf=%0b expected all 0",
               bus.BUSY, bus.MDONE, bus.CF, bus.ZF);
    end
    bus.Ep = 1'b1;
    #1;
    checks++;
    if (DBUS !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_prod: got %0h expected 0", DBUS);
    end
    saw_activity = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      if (bus.BUSY !== 1'b0 || bus.MDONE !== 1'b0 || DBUS !== 8'h00) saw_activity = 1'b1;
    end
    bus.Ep = 1'b0;
    checks++;
    if (saw_activity !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_aborted: got activity=%0b expected 0", saw_activity);
    end
    $display("reset mid-multiply checked");
    do_mul(8'h2B, 8'h06);
  endtask

  task automatic test_back_to_back(input int a, input int b);
    int p;
    p = a * b;
    load_b(b);
    bus.ACC = W'(a);
    bus.Mu = 1'b1;
    tick();
    for (int k = 1; k <= W + 1; k++) begin
      checks++;
      if (bus.BUSY !== 1'b1 || bus.MDONE !== (k == W + 1)) begin
        errors++;
        $display("FAIL b2b_first: cycle %0d got busy=%0b mdone=%0b", k, bus.BUSY, bus.MDONE);
      end
      tick();
    end
    bus.Ep = 1'b1;
    #1;
    checks++;
    if (bus.BUSY !== 1'b0 || DBUS !== W'(p & MASK)) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy=%0b bus=%0h expected 0 %0h", bus.BUSY, DBUS, W'(p & MASK));
    end
    bus.Ep = 1'b0;
    tick();
    bus.Mu = 1'b0;
    bus.ACC = 8'h01;
    checks++;
    if (bus.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%0b expected 1", bus.BUSY);
    end
    for (int k = 1; k <= W + 1; k++) tick();
    bus.Ep = 1'b1;
    #1;
    m_prod = p;
    m_cf = (p > MASK);
    m_zf = (p == 0);
    checks++;
    if ({bus.BUSY, bus.CF, bus.ZF} !== {1'b0, m_cf, m_zf} || DBUS !== W'(p & MASK)) begin
      errors++;
      $display("FAIL b2b_second: got busy=%0b cf=%0b zf=%0b bus=%0h expected 0 %0b %0b %0h",
               bus.BUSY, bus.CF, bus.ZF, DBUS, m_cf, m_zf, W'(p & MASK));
    end
    bus.Ep = 1'b0;
    $display("back-to-back a=%02h b=%02h -> prod=%04h", a, b, p);
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    bus.ACC = '0;
    test_reset();
    test_add();
    test_sub();
    test_random_addsub();
    test_multiply();
    test_interference(8'h0C, 8'h0D);
    test_interference(int'($urandom_range(1, MASK)), int'($urandom_range(1, MASK)));
    test_reset_mid();
    test_back_to_back(8'h1F, 8'h23);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
